// File: rtl/sw_pkg.sv
// Shared switch package: port count, scheduler state encoding and small helpers.
// PORT and PKTW fall back to the standard 4x4 switch values when sw.vh is not in the build.
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 32
`endif

package sw_pkg;

  localparam int NPORT        = `PORT + 1;
  localparam int CRED_MAX_DEF = 4;
  localparam int TIMEOUT_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_st_t;

  // Round-robin successor of requester v among n requesters.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/out_sched_if.sv
// Output-port scheduler bus: requests and tails from the input buffers,
// grant/ack back to them, and the credit return from the downstream buffer.
interface out_sched_if
  import sw_pkg::*;
#(
  parameter int N  = NPORT,
  parameter int CW = $clog2(CRED_MAX_DEF + 1)
);

  logic [N-1:0]  req;
  logic [N-1:0]  tail;
  logic          cred_ret;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic          busy;
  logic [CW-1:0] cred;
  logic          err;

  modport master (
    output req, tail, cred_ret,
    input  gnt, ack, busy, cred, err
  );

  modport slave (
    input  req, tail, cred_ret,
    output gnt, ack, busy, cred, err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot first set request scanning
// ptr, ptr+1, ... mod N; shared by the switch arbiters.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic [PW-1:0] idx;

  // Scan from the far end back towards ptr so the last hit is the winner.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pick = '0;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/out_sched.sv
// Per-output-port packet scheduler: round-robin grant held for a whole packet,
// transfers gated by downstream credits. OUT_SCHED_WATCHDOG_EN adds a stalled-lock breaker.
module out_sched
  import sw_pkg::*;
#(
  parameter int N        = NPORT,
  parameter int CRED_MAX = CRED_MAX_DEF,
  parameter int CW       = $clog2(CRED_MAX + 1)
`ifdef OUT_SCHED_WATCHDOG_EN
  ,
  parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input logic        clk,
  input logic        rst,
  out_sched_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CRED_FULL = CW'(CRED_MAX);

  sched_st_t     state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] nxt_ptr;
  logic [N-1:0]  pick;
  logic          any;
  logic          cred_ok;
  logic          xfer;
  logic          last_xfer;
  logic          cred_ovf;

`ifdef OUT_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;
`endif

  rr_pick #(.N(N)) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // gnt is zero outside LOCK, so ack can never fire while idle.
  assign cred_ok   = (bus.cred != '0);
  assign bus.ack   = bus.gnt & bus.req & {N{cred_ok}};
  assign xfer      = |bus.ack;
  assign last_xfer = |(bus.ack & bus.tail);
  assign cred_ovf  = bus.cred_ret & ~xfer & (bus.cred == CRED_FULL);
  assign bus.busy  = (state == LOCK);

  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) owner = PW'(i);
    end
  end

  assign nxt_ptr = PW'(wrap_inc(int'(owner), N));

  // NOTE: registered state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bus.gnt  <= '0;
      ptr      <= '0;
      bus.cred <= CRED_FULL;
      bus.err  <= 1'b0;
`ifdef OUT_SCHED_WATCHDOG_EN
      stall_cnt <= '0;
`endif
    end else begin
      if (cred_ovf) bus.err <= 1'b1;

      if (xfer && !bus.cred_ret) begin
        bus.cred <= bus.cred - CW'(1);
      end else if (!xfer && bus.cred_ret && bus.cred != CRED_FULL) begin
        bus.cred <= bus.cred + CW'(1);
      end

      case (state)
        IDLE: begin
          if (any && cred_ok) begin
            bus.gnt <= pick;
            state   <= LOCK;
          end
`ifdef OUT_SCHED_WATCHDOG_EN
          stall_cnt <= '0;
`endif
        end

        LOCK: begin
          // ptr only moves when a packet ends, never on a grant.
          if (last_xfer) begin
            state   <= IDLE;
            bus.gnt <= '0;
            ptr     <= nxt_ptr;
          end
`ifdef OUT_SCHED_WATCHDOG_EN
          if (xfer) begin
            stall_cnt <= '0;
          end else if (cred_ok) begin
            if (stall_cnt == TW'(TIMEOUT - 1)) begin
              state     <= IDLE;
              bus.gnt   <= '0;
              ptr       <= nxt_ptr;
              bus.err   <= 1'b1;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + TW'(1);
            end
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_sched.sv
// Self-checking bench for out_sched: a packet-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_out_sched;

  localparam int N        = 4;
  localparam int CRED_MAX = 4;
  localparam int TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loop = 1'b0;
  logic ret_m = 1'b0;
  logic chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner, m_ptr, m_cred, m_stall;
  bit m_err;

  logic [3:0] s1_gnt [5];

  out_sched_if #(.N(N), .CW(3)) bus ();

  out_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Credit loopback: downstream frees a slot in the same cycle a flit is taken.
  assign bus.cred_ret = loop ? |bus.ack : ret_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ack();
    if (m_owner >= 0 && bus.req[2'(m_owner)] && m_cred > 0) return 4'(1 << m_owner);
    return 4'b0;
  endfunction

  // Packet-level model: owner index (-1 when idle), rotation pointer, credit count.
  always @(posedge clk or negedge rst) begin : model
    int o, p, c, s;
    bit e, xf, ret, found;
    if (!rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_cred  <= CRED_MAX;
      m_err   <= 1'b0;
      m_stall <= 0;
    end else begin
      o = m_owner; p = m_ptr; c = m_cred; e = m_err; s = m_stall;
      xf  = (exp_ack() != 4'b0);
      ret = loop ? xf : ret_m;
      if (o < 0) begin
        s = 0;
        found = 1'b0;
        if (c > 0) begin
          for (int k = 0; k < N; k++) begin
            if (!found && bus.req[2'((p + k) % N)]) begin
              o = (p + k) % N;
              found = 1'b1;
            end
          end
        end
      end else if (xf && bus.tail[2'(o)]) begin
        p = (o + 1) % N;
        o = -1;
      end
`ifdef OUT_SCHED_WATCHDOG_EN
      else if (xf) s = 0;
      else if (c > 0) begin
        s++;
        if (s == TIMEOUT) begin
          p = (o + 1) % N;
          o = -1;
          e = 1'b1;
          s = 0;
        end
      end
`endif
      if (ret && !xf && c == CRED_MAX) e = 1'b1;
      else c = c - int'(xf) + int'(ret);
      m_owner <= o;
      m_ptr   <= p;
      m_cred  <= c;
      m_err   <= e;
      m_stall <= s;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_on) begin
      check("gnt",  32'(bus.gnt),  (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      check("ack",  32'(bus.ack),  32'(exp_ack()));
      check("busy", 32'(bus.busy), 32'(m_owner >= 0));
      check("cred", 32'(bus.cred), 32'(m_cred));
      check("err",  32'(bus.err),  32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    loop = 1'b0;
    ret_m = 1'b0;
    bus.req = '0;
    bus.tail = '0;
    #4;
    rst = 1'b1;
  endtask

  initial begin
    bus.req  = '0;
    bus.tail = '0;
    s1_gnt = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};

    #12;
    check("rst_gnt",  32'(bus.gnt),  32'd0);
    check("rst_ack",  32'(bus.ack),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cred", 32'(bus.cred), 32'd4);
    check("rst_err",  32'(bus.err),  32'd0);
    chk_on = 1'b1;

    // Two requesters, single-flit packets: alternate grants with an idle cycle between.
    do_reset();
    loop = 1'b1;
    bus.req = 4'b0101;
    bus.tail = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(s1_gnt[k]));
      check("rr_cred", 32'(bus.cred), 32'd4);
    end

    // Move ptr to 2, then a 3-flit packet from buffer 2 must not be interrupted by buffer 0.
    do_reset();
    loop = 1'b1;
    bus.req = 4'b0010;
    bus.tail = 4'b1111;
    tick();
    check("pre_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    bus.req = 4'b0101;
    bus.tail = 4'b0000;
    tick();
    check("pkt_f1_gnt", 32'(bus.gnt), 32'b0100);
    check("pkt_f1_ack", 32'(bus.ack), 32'b0100);
    tick();
    check("pkt_f2_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    check("pkt_f3_gnt", 32'(bus.gnt), 32'b0100);
    bus.tail = 4'b0100;
    tick();
    check("pkt_end_gnt", 32'(bus.gnt), 32'b0000);
    check("pkt_end_busy", 32'(bus.busy), 32'd0);
    bus.tail = 4'b0001;
    tick();
    check("pkt_next_gnt", 32'(bus.gnt), 32'b0001);

    // Credit exhaustion: four flits go, the fifth waits with the lock held.
    do_reset();
    bus.req = 4'b0010;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("cr_ack", 32'(bus.ack), 32'b0010);
      check("cr_cred", 32'(bus.cred), 32'(4 - k));
      tick();
    end
    check("cr0_ack", 32'(bus.ack), 32'd0);
    check("cr0_cred", 32'(bus.cred), 32'd0);
    check("cr0_gnt", 32'(bus.gnt), 32'b0010);
    check("cr0_busy", 32'(bus.busy), 32'd1);
    ret_m = 1'b1;
    tick();
    ret_m = 1'b0;
    check("cr1_cred", 32'(bus.cred), 32'd1);
    check("cr1_ack", 32'(bus.ack), 32'b0010);
    tick();
    check("cr1_after_cred", 32'(bus.cred), 32'd0);
    check("cr1_after_ack", 32'(bus.ack), 32'd0);

    // Credit return at full credit sets sticky err; transfer plus return keeps cred.
    do_reset();
    ret_m = 1'b1;
    tick();
    ret_m = 1'b0;
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_cred", 32'(bus.cred), 32'd4);
    bus.req = 4'b0010;
    tick();
    tick();
    tick();
    check("bal_pre_cred", 32'(bus.cred), 32'd2);
    ret_m = 1'b1;
    tick();
    ret_m = 1'b0;
    check("bal_cred", 32'(bus.cred), 32'd2);
    check("ovf_sticky", 32'(bus.err), 32'd1);

    // Asynchronous reset mid-packet with cred=1.
    do_reset();
    bus.req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    check("ar_pre_cred", 32'(bus.cred), 32'd1);
    check("ar_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_cred", 32'(bus.cred), 32'd4);
    check("ar_err", 32'(bus.err), 32'd0);

`ifdef OUT_SCHED_WATCHDOG_EN
    // Owner withdraws mid-packet: lock broken on the 16th stalled cycle.
    do_reset();
    loop = 1'b1;
    bus.req = 4'b0010;
    tick();
    check("wd_gnt0", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0100;
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    check("wd_hold_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    check("wd_break_gnt", 32'(bus.gnt), 32'd0);
    check("wd_break_err", 32'(bus.err), 32'd1);
    tick();
    check("wd_next_gnt", 32'(bus.gnt), 32'b0100);
`endif

    do_reset();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
